// File: rtl/md_pkg.sv
// Shared opcode and state encodings for the HI/LO multiply/divide unit.
// Also used by ControllerE and the hazard unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_result_calc.sv
// Combinational HI/LO result for MULT/MULTU/DIV/DIVU, including the
// divide-by-zero and signed-overflow corner cases.
module md_result_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic               signed_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH-1:0]   div_b_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // Sign-extend for the signed ops so one 2W-bit product serves both; divide on magnitudes
    always_comb begin
        signed_s = (op == MD_MULT) || (op == MD_DIV);
        a_neg_s  = signed_s & a[WIDTH-1];
        b_neg_s  = signed_s & b[WIDTH-1];
        prod_s   = {{WIDTH{a_neg_s}}, a} * {{WIDTH{b_neg_s}}, b};
        mag_a_s  = a_neg_s ? (~a + ONE) : a;
        mag_b_s  = b_neg_s ? (~b + ONE) : b;
        div_b_s  = (b == '0) ? ONE : mag_b_s;
        quo_s    = mag_a_s / div_b_s;
        rem_s    = mag_a_s % div_b_s;
        res_hi   = '0;
        res_lo   = '0;
        case (md_op_e'(op))
            MD_MULT, MD_MULTU: begin
                {res_hi, res_lo} = prod_s;
            end
            MD_DIV, MD_DIVU: begin
                if (b == '0) begin
                    res_lo = '1;
                    res_hi = a;
                end else if ((op == MD_DIV) && (a == MIN_INT) && (b == '1)) begin
                    res_lo = MIN_INT;
                    res_hi = '0;
                end else begin
                    res_lo = (a_neg_s ^ b_neg_s) ? (~quo_s + ONE) : quo_s;
                    res_hi = a_neg_s ? (~rem_s + ONE) : rem_s;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit_param.sv
// HI/LO multiply/divide unit: result is computed at issue, held pending for the
// configured latency, and committed to HI/LO unless cancelled first.
module md_unit_param
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CW      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] calc_hi_s, calc_lo_s;
    logic             accept_s;
    logic             commit_s;

    md_result_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (calc_hi_s),
        .res_lo (calc_lo_s)
    );

    // Cancel outranks both a new start and a final-cycle commit
    assign accept_s = (state_q == MD_IDLE) && start && !cancel;
    assign commit_s = (state_q == MD_RUN) && !cancel && (cnt_q == '0);

    // State register, counter, pending result and architectural HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state, latency counter and pending-result capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            MD_IDLE: begin
                if (accept_s && (md_is_mul(op) || md_is_div(op))) begin
                    state_d   = MD_RUN;
                    cnt_d     = md_is_mul(op) ? MUL_LOAD : DIV_LOAD;
                    pend_hi_d = calc_hi_s;
                    pend_lo_d = calc_lo_s;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_RUN: begin
                if (cancel || commit_s) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    // HI/LO writes and the registered busy/done outputs
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit_s) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end else if (accept_s && (op == MD_MTHI)) begin
            hi_d = a;
        end else if (accept_s && (op == MD_MTLO)) begin
            lo_d = a;
        end else begin
            hi_d = hi_q;
        end
        busy_d = (state_d == MD_RUN);
        done_d = commit_s;
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
